// File: rtl/lsf_pkg.sv
// Shared definitions for the LSF r-bin accumulator: FSM state encoding and default sizing.
package lsf_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2
  } racc_state_e;

  localparam int LSF_W_BIN_DEF = 7;
  localparam int LSF_RBINS_DEF = 128;
  localparam int LSF_W_CNT_DEF = 4;

endpackage

// File: rtl/lsf_racc_argmax.sv
// Running argmax tracker: keeps the first (lowest-index) bin holding the strictly largest count.
module lsf_racc_argmax #(
  parameter int W_IDX = 7,
  parameter int W_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vld,
  input  logic [W_IDX-1:0] idx,
  input  logic [W_CNT-1:0] count,
  output logic [W_IDX-1:0] best_bin,
  output logic [W_CNT-1:0] best_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_bin   <= '0;
      best_count <= '0;
    end else if (start) begin
      best_bin   <= '0;
      best_count <= '0;
    end else if (vld && (count > best_count)) begin
      best_bin   <= idx;
      best_count <= count;
    end
  end

endmodule

// File: rtl/lsf_r_bin_accumulator.sv
// Hough r-bin vote accumulator with per-event argmax scan.
// Optional drop counter output enabled by defining LSF_RACC_DROP_CNT_EN.
//
// state | meaning
// ACCUM | votes accepted, counters increment (saturating)
// SCAN  | one bin per cycle compared against best, then cleared
// DONE  | single-cycle max_vld strobe with the winning bin
module lsf_r_bin_accumulator
  import lsf_pkg::*;
#(
  parameter int W_bin_number_a = LSF_W_BIN_DEF,
  parameter int RBINS          = LSF_RBINS_DEF,
  parameter int W_CNT          = LSF_W_CNT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [W_bin_number_a-1:0] r_bin,
  input  logic                      r_bin_vld,
  input  logic                      evt_done,
  output logic                      ready,
  output logic [W_bin_number_a-1:0] max_bin,
  output logic [W_CNT-1:0]          max_count,
  output logic                      max_vld
`ifdef LSF_RACC_DROP_CNT_EN
  , output logic [7:0]              drop_cnt
`endif
);

  localparam logic [W_bin_number_a-1:0] LAST_IDX = W_bin_number_a'(RBINS - 1);
  localparam logic [W_CNT-1:0]          CNT_MAX  = '1;

  racc_state_e state_q, state_d;

  logic [W_bin_number_a-1:0] scan_idx;
  logic [W_CNT-1:0]          cnt [RBINS];
  logic [W_CNT-1:0]          scan_cnt;
  logic                      accum, scanning, start;
  logic [W_bin_number_a-1:0] best_bin, max_bin_q;
  logic [W_CNT-1:0]          best_count, max_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accum     = 1'b0;
    scanning  = 1'b0;
    max_vld   = 1'b0;
    max_bin   = max_bin_q;
    max_count = max_count_q;
    case (state_q)
      ACCUM: begin
        accum = 1'b1;
        if (evt_done) state_d = SCAN;
      end
      SCAN: begin
        scanning = 1'b1;
        if (scan_idx == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        max_vld   = 1'b1;
        max_bin   = best_bin;
        max_count = best_count;
        state_d   = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign ready = accum;
  assign start = accum && evt_done;

  // Increment and clear share one process; a bin is never in both paths at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RBINS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < RBINS; i++) begin
        if (scanning && (scan_idx == W_bin_number_a'(i)))
          cnt[i] <= '0;
        else if (accum && r_bin_vld && (r_bin == W_bin_number_a'(i)) && (cnt[i] != CNT_MAX))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < RBINS; i++)
      if (scan_idx == W_bin_number_a'(i)) scan_cnt = cnt[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             scan_idx <= '0;
    else if (scanning && scan_idx != LAST_IDX) scan_idx <= scan_idx + 1'b1;
    else                                    scan_idx <= '0;
  end

  lsf_racc_argmax #(
    .W_IDX (W_bin_number_a),
    .W_CNT (W_CNT)
  ) u_argmax (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vld        (scanning),
    .idx        (scan_idx),
    .count      (scan_cnt),
    .best_bin   (best_bin),
    .best_count (best_count)
  );

  // Result is captured on leaving DONE so outputs hold until the next strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_bin_q   <= '0;
      max_count_q <= '0;
    end else if (state_q == DONE) begin
      max_bin_q   <= best_bin;
      max_count_q <= best_count;
    end
  end

`ifdef LSF_RACC_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         drop_cnt <= '0;
    else if (r_bin_vld && !accum && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_lsf_r_bin_accumulator.sv
// Self-checking bench for lsf_r_bin_accumulator (default build and LSF_RACC_DROP_CNT_EN build).
module tb_lsf_r_bin_accumulator;

  localparam int RB   = 128;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] r_bin = '0;
  logic       r_bin_vld = 1'b0, evt_done = 1'b0;
  logic       ready, max_vld;
  logic [6:0] max_bin;
  logic [3:0] max_count;
  logic [6:0] r_bin2 = '0;
  logic       r_bin_vld2 = 1'b0, evt_done2 = 1'b0;
  logic       ready2, max_vld2;
  logic [6:0] max_bin2;
  logic [3:0] max_count2;
`ifdef LSF_RACC_DROP_CNT_EN
  logic [7:0] drop_cnt, drop_cnt2;
`endif

  always #5 clk = ~clk;

  lsf_r_bin_accumulator dut (
    .clk(clk), .rst_n(rst_n), .r_bin(r_bin), .r_bin_vld(r_bin_vld), .evt_done(evt_done),
    .ready(ready), .max_bin(max_bin), .max_count(max_count), .max_vld(max_vld)
`ifdef LSF_RACC_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  lsf_r_bin_accumulator #(.RBINS(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .r_bin(r_bin2), .r_bin_vld(r_bin_vld2), .evt_done(evt_done2),
    .ready(ready2), .max_bin(max_bin2), .max_count(max_count2), .max_vld(max_vld2)
`ifdef LSF_RACC_DROP_CNT_EN
    , .drop_cnt(drop_cnt2)
`endif
  );

  typedef struct {
    string name;
    int    bin_a, n_a, bin_b, n_b;
    int    exp_bin, exp_cnt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt [RB];
  int model_drops = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < RB; i++) model_cnt[i] = 0;
  endfunction

  function automatic void model_vote(input int bin);
    if (bin < RB && model_cnt[bin] < CMAX) model_cnt[bin] = model_cnt[bin] + 1;
  endfunction

  function automatic void model_best(output int b, output int c);
    b = 0; c = 0;
    for (int i = 0; i < RB; i++)
      if (model_cnt[i] > c) begin b = i; c = model_cnt[i]; end
  endfunction

  function automatic int sat_drops();
    return (model_drops > 255) ? 255 : model_drops;
  endfunction

  task automatic drive(input bit v, input int b, input bit d);
    @(negedge clk);
    r_bin_vld = v; r_bin = 7'(b); evt_done = d;
    if (v) model_vote(b);
  endtask

  // Called right after the evt_done cycle has been driven; n counts cycles after that edge.
  task automatic finish_event(input int eb, input int ec, input bit junk, input string name);
    bit seen = 1'b0;
    for (int n = 1; n <= RB + 40 && !seen; n++) begin
      @(negedge clk);
      if (max_vld) begin
        seen = 1'b1;
        check({name, " latency"}, n, RB + 1);
        check({name, " max_bin"}, max_bin, eb);
        check({name, " max_count"}, max_count, ec);
      end else if (n == 1) begin
        check({name, " ready in scan"}, ready, 0);
      end
      if (junk && !seen && n <= RB) begin
        r_bin_vld = 1'($urandom_range(0, 1));
        r_bin     = 7'($urandom);
        evt_done  = 1'($urandom_range(0, 1));
        if (r_bin_vld) model_drops++;
      end else begin
        r_bin_vld = 1'b0; evt_done = 1'b0;
      end
    end
    if (!seen) check({name, " max_vld timeout"}, 0, 1);
    model_clear();
    @(negedge clk);
    check({name, " ready after"}, ready, 1);
    check({name, " strobe width"}, max_vld, 0);
    check({name, " max_bin hold"}, max_bin, eb);
    check({name, " max_count hold"}, max_count, ec);
`ifdef LSF_RACC_DROP_CNT_EN
    check({name, " drop_cnt"}, drop_cnt, sat_drops());
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    int eb, ec, nv;
    bit v;
    int b;
    bit seen;

    vecs[0] = '{"bins5x3_9x2",   5, 3,   9, 2,   5, 3};
    vecs[1] = '{"tie20_10",     20, 2,  10, 2,  10, 2};
    vecs[2] = '{"sat7",          7, 20,  0, 0,   7, 15};
    vecs[3] = '{"empty",         0, 0,   0, 0,   0, 0};
    vecs[4] = '{"cleared7",      7, 1,   0, 0,   7, 1};
    vecs[5] = '{"last_bin",    127, 1,   0, 0, 127, 1};
    vecs[6] = '{"tie0_127",    127, 1,   0, 1,   0, 1};
    vecs[7] = '{"bin0_win",      0, 4, 126, 3,   0, 4};

    model_clear();
    #3;
    check("reset ready", ready, 1);
    check("reset max_vld", max_vld, 0);
    check("reset max_bin", max_bin, 0);
    check("reset max_count", max_count, 0);
`ifdef LSF_RACC_DROP_CNT_EN
    check("reset drop_cnt", drop_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < vecs[t].n_a; k++) drive(1, vecs[t].bin_a, 0);
      for (int k = 0; k < vecs[t].n_b; k++) drive(1, vecs[t].bin_b, 0);
      drive(0, 0, 1);
      finish_event(vecs[t].exp_bin, vecs[t].exp_cnt, 0, vecs[t].name);
    end

    for (int e = 0; e < 12; e++) begin
      nv = $urandom_range(0, 40);
      for (int k = 0; k <= nv; k++) begin
        v = ($urandom_range(0, 3) != 0);
        b = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 7);
        drive(v, b, (k == nv));
      end
      model_best(eb, ec);
      finish_event(eb, ec, 1, "random");
    end

    // Reset in the middle of a scan with dropped votes pending.
    drive(1, 2, 0);
    drive(1, 2, 0);
    drive(0, 0, 1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      r_bin_vld = 1'b1; r_bin = 7'd9; evt_done = 1'b0;
      model_drops++;
    end
    @(negedge clk);
    r_bin_vld = 1'b0;
    check("midscan ready", ready, 0);
`ifdef LSF_RACC_DROP_CNT_EN
    check("midscan drop_cnt", drop_cnt, sat_drops());
`endif
    #2 rst_n = 1'b0;
    #1;
    check("rst ready", ready, 1);
    check("rst max_vld", max_vld, 0);
    check("rst max_bin", max_bin, 0);
    check("rst max_count", max_count, 0);
`ifdef LSF_RACC_DROP_CNT_EN
    check("rst drop_cnt", drop_cnt, 0);
`endif
    model_clear();
    model_drops = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("rst no max_vld", max_vld, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    r_bin_vld = 1'b1; r_bin = 7'd3; evt_done = 1'b0;
    model_vote(3);
    drive(0, 0, 1);
    finish_event(3, 1, 0, "post_reset");

    // RBINS=64 instance: out-of-range votes ignored.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      r_bin_vld2 = 1'b1; r_bin2 = (k < 4) ? 7'd100 : 7'd3;
    end
    @(negedge clk);
    r_bin_vld2 = 1'b0; evt_done2 = 1'b1;
    seen = 1'b0;
    for (int n = 1; n <= 120 && !seen; n++) begin
      @(negedge clk);
      evt_done2 = 1'b0;
      if (max_vld2) begin
        seen = 1'b1;
        check("r64 latency", n, 65);
        check("r64 max_bin", max_bin2, 3);
        check("r64 max_count", max_count2, 1);
      end
    end
    if (!seen) check("r64 max_vld timeout", 0, 1);
    @(negedge clk);
    check("r64 ready after", ready2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsf_r_bin_accumulator.md
LSF_R_BIN_ACCUMULATOR -- requirements
Module: lsf_r_bin_accumulator

Interface
REQ-001 Parameter W_bin_number_a, default 7: width of the r_bin input.
REQ-002 Parameter RBINS, default 128: number of r bins accumulated, 2 <= RBINS <= 2**W_bin_number_a.
REQ-003 Parameter W_CNT, default 4: width of each bin vote counter.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 r_bin  in  W_bin_number_a  r bin index from the upstream r-bin computation stage.
REQ-007 r_bin_vld  in  1  r_bin qualifier; one vote per cycle high.
REQ-008 evt_done  in  1  single-cycle pulse marking the last vote of the current event.
REQ-009 ready  out  1  high while votes are accepted (state ACCUM).
REQ-010 max_bin  out  W_bin_number_a  index of the winning bin.
REQ-011 max_count  out  W_CNT  vote count of the winning bin.
REQ-012 max_vld  out  1  single-cycle strobe qualifying max_bin and max_count.

Function
REQ-013 The block SHALL hold RBINS flop-based counters, with no RAM, so back-to-back votes to the same bin never hazard.
REQ-014 The FSM SHALL have three states: ACCUM, SCAN and DONE.
REQ-015 ACCUM: ready=1; r_bin_vld=1 with r_bin<RBINS SHALL increment count[r_bin] by 1 on the same clock edge, saturating at 2**W_CNT-1.
REQ-016 A vote with r_bin>=RBINS SHALL be ignored, with no counter change.
REQ-017 In ACCUM, evt_done=1 SHALL move the FSM to SCAN; a vote in the same cycle SHALL still be counted.
REQ-018 SCAN: ready=0; an index counter SHALL step 0..RBINS-1, one bin per cycle; each visited bin SHALL be compared and then cleared to 0 in the same cycle.
REQ-019 Argmax rule: the best bin SHALL update only if count[idx] > best_count (strict), so ties resolve to the lowest index; best_count and best_bin SHALL initialise to 0 at SCAN entry.
REQ-020 After idx=RBINS-1 the FSM SHALL enter DONE for exactly one cycle: max_vld=1, max_bin=best_bin, max_count=best_count; next state ACCUM.
REQ-021 Latency: with evt_done sampled at edge T, max_vld SHALL be high during cycle T+RBINS+1 and ready SHALL be high again at T+RBINS+2.
REQ-022 An event with no votes SHALL still produce max_vld with max_bin=0 and max_count=0.
REQ-023 r_bin_vld while ready=0 SHALL be dropped, with no counter change.
REQ-024 evt_done in SCAN or DONE SHALL be ignored.
REQ-025 max_bin and max_count SHALL hold their values between strobes; max_vld SHALL be 0 except in DONE.

Reset
REQ-026 rst_n=0 SHALL asynchronously force all counters to 0, state to ACCUM, ready=1, max_vld=0, max_bin=0, max_count=0, and the scan index, best_bin and best_count to 0.
REQ-027 Reset asserted mid-SCAN SHALL abort the scan with no max_vld; the first cycle after release SHALL accept votes.

Configuration
REQ-028 Macro LSF_RACC_DROP_CNT_EN, when defined, SHALL add output port drop_cnt [7:0].
REQ-029 With the macro defined, drop_cnt SHALL count r_bin_vld cycles with ready=0, saturating at 255, clearing on reset only.
REQ-030 With the macro undefined, drop_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 The FSM state enum (ACCUM, SCAN, DONE) and the default constants for RBINS and W_CNT SHALL live in the shared lsf package.
REQ-032 The compare/track logic SHALL be one sub-module, lsf_racc_argmax: inputs start, vld, idx and count; outputs best_bin and best_count.

Verification
REQ-033 Votes r_bin=5 x3, r_bin=9 x2, then evt_done -> max_vld exactly 129 cycles after the evt_done edge, with max_bin=5 and max_count=3.
REQ-034 Votes bins 20 and 10, two each -> max_bin=10, max_count=2 (tie to lowest index).
REQ-035 20 votes to bin 7 with W_CNT=4 -> max_count=15.
REQ-036 evt_done with no votes -> max_vld with max_bin=0 and max_count=0; the next event's counters SHALL all start at 0.
REQ-037 RBINS=64: votes r_bin=100 x4 and r_bin=3 x1 -> max_bin=3, max_count=1.
REQ-038 Votes during SCAN plus rst_n pulsed mid-SCAN -> no max_vld, ready=1 after release, and with LSF_RACC_DROP_CNT_EN defined drop_cnt equal to the number of dropped votes before reset and 0 after.
